// File: rtl/puanli_denetim_durum_birimi.sv
// puanli_denetim_durum_birimi
// Hazard/control unit beside COZ: two-source operand forwarding, a register
// scoreboard for in-flight multi-cycle results, an outstanding-operation
// limit, a multi-cycle flush window after a misprediction and a sticky
// stall watchdog. Drives the stall/flush controls for GETIR and COZ.
module puanli_denetim_durum_birimi #(
    parameter int YAZMAC_SAYISI  = 32,
    parameter int ADRES_GENISLIK = 5,
    parameter int IZ_DERINLIK    = 4,
    parameter int BOSALT_CEVRIM  = 1,
    parameter int ZAMAN_ASIMI    = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      coz_gecerli_i,
    input  logic [ADRES_GENISLIK-1:0] rs1_adres_coz_i,
    input  logic [ADRES_GENISLIK-1:0] rs2_adres_coz_i,
    input  logic [ADRES_GENISLIK-1:0] rd_adres_coz_i,
    input  logic                      rs1_kullan_coz_i,
    input  logic                      rs2_kullan_coz_i,
    input  logic                      yaz_yazmac_coz_i,
    input  logic                      cok_cevrim_coz_i,
    input  logic                      yaz_yazmac_yurut_i,
    input  logic [ADRES_GENISLIK-1:0] rd_adres_yurut_i,
    input  logic                      yaz_yazmac_geriyaz_i,
    input  logic [ADRES_GENISLIK-1:0] rd_adres_geriyaz_i,
    input  logic                      tamam_gecerli_i,
    input  logic [ADRES_GENISLIK-1:0] tamam_rd_adres_i,
    input  logic                      program_sayaci_gecerli_i,
    input  logic                      tahmin_dogru_i,
    input  logic                      getir_bekle_i,
    output logic [1:0]                yonlendir_deger1_o,
    output logic [1:0]                yonlendir_deger2_o,
    output logic                      durdur_getir_o,
    output logic                      durdur_coz_o,
    output logic                      bosalt_getir_o,
    output logic                      bosalt_coz_o,
    output logic [YAZMAC_SAYISI-1:0]  puan_mesgul_o,
    output logic                      zaman_asimi_o
);

    // Counter widths: the flush counter only needs to hold BOSALT_CEVRIM-1,
    // the outstanding counter 0..IZ_DERINLIK, the watchdog 0..ZAMAN_ASIMI.
    localparam int BW = (BOSALT_CEVRIM > 1) ? $clog2(BOSALT_CEVRIM) : 1;
    localparam int KW = (IZ_DERINLIK > 0) ? $clog2(IZ_DERINLIK + 1) : 1;
    localparam int ZW = (ZAMAN_ASIMI > 0) ? $clog2(ZAMAN_ASIMI + 1) : 1;

    localparam logic [BW-1:0]             BOSALT_YUKLE = BW'(BOSALT_CEVRIM - 1);
    localparam logic [KW-1:0]             IZ_SINIR     = KW'(IZ_DERINLIK);
    localparam logic [ZW-1:0]             ZA_SINIR     = ZW'(ZAMAN_ASIMI);
    localparam logic [ADRES_GENISLIK-1:0] X0           = '0;

    typedef enum logic [1:0] {
        HICBISEY = 2'd0,
        YURUT    = 2'd1,
        GERIYAZ  = 2'd2
    } yonlendir_e;

    // One-hot decode of a register address; addresses beyond the register
    // file decode to all zeros so they never touch a busy bit.
    function automatic logic [YAZMAC_SAYISI-1:0] tekli(input logic [ADRES_GENISLIK-1:0] adres);
        logic [YAZMAC_SAYISI-1:0] sonuc;
        sonuc = '0;
        for (int i = 0; i < YAZMAC_SAYISI; i++) begin
            sonuc[i] = (adres == ADRES_GENISLIK'(i));
        end
        return sonuc;
    endfunction

    // Forwarding source for one operand; the younger YURUT result wins.
    function automatic yonlendir_e yonlendir_sec(input logic [ADRES_GENISLIK-1:0] rs);
        yonlendir_e sec;
        sec = HICBISEY;
        if (rs != X0 && yaz_yazmac_yurut_i && rs == rd_adres_yurut_i) begin
            sec = YURUT;
        end else if (rs != X0 && yaz_yazmac_geriyaz_i && rs == rd_adres_geriyaz_i) begin
            sec = GERIYAZ;
        end
        return sec;
    endfunction

    logic [YAZMAC_SAYISI-1:0] r_mesgul;
    logic [KW-1:0]            r_bekleyen;
    logic [BW-1:0]            r_bosalt_sayac;
    logic [ZW-1:0]            r_bekci;
    logic                     r_zaman_asimi;

    logic [YAZMAC_SAYISI-1:0] w_tamam_maske;
    logic [YAZMAC_SAYISI-1:0] w_mesgul_e;
    logic [YAZMAC_SAYISI-1:0] w_set_maske;
    logic                     w_rs1_tehlike;
    logic                     w_rs2_tehlike;
    logic                     w_waw_tehlike;
    logic                     w_dolu;
    logic                     w_tehlike;
    logic                     w_yanlis;
    logic                     w_bosalt;
    logic                     w_durdur_coz;
    logic                     w_verilen;
    logic                     w_tamam_say;

    // A completion this cycle releases its register immediately, so the
    // dependent instruction is not held one extra cycle.
    assign w_tamam_maske = tamam_gecerli_i ? tekli(tamam_rd_adres_i) : '0;
    assign w_mesgul_e    = r_mesgul & ~w_tamam_maske;

    assign w_rs1_tehlike = rs1_kullan_coz_i && rs1_adres_coz_i != X0
                           && |(w_mesgul_e & tekli(rs1_adres_coz_i));
    assign w_rs2_tehlike = rs2_kullan_coz_i && rs2_adres_coz_i != X0
                           && |(w_mesgul_e & tekli(rs2_adres_coz_i));
    assign w_waw_tehlike = yaz_yazmac_coz_i && rd_adres_coz_i != X0
                           && |(w_mesgul_e & tekli(rd_adres_coz_i));
    // A completion in the same cycle frees a slot for the new operation.
    assign w_dolu        = cok_cevrim_coz_i && (r_bekleyen == IZ_SINIR) && !tamam_gecerli_i;
    assign w_tehlike     = coz_gecerli_i
                           && (w_rs1_tehlike || w_rs2_tehlike || w_waw_tehlike || w_dolu);

    assign w_yanlis      = program_sayaci_gecerli_i && !tahmin_dogru_i;
    assign w_bosalt      = w_yanlis || (r_bosalt_sayac != '0);

    // Flush overrides stall: the instructions being held are discarded anyway.
    assign w_durdur_coz  = (w_tehlike || getir_bekle_i) && !w_bosalt;
    assign w_verilen     = coz_gecerli_i && cok_cevrim_coz_i && !w_durdur_coz && !w_bosalt;
    assign w_set_maske   = (w_verilen && yaz_yazmac_coz_i && rd_adres_coz_i != X0)
                           ? tekli(rd_adres_coz_i) : '0;
    // Completions with nothing outstanding are spurious and must not underflow.
    assign w_tamam_say   = tamam_gecerli_i && (r_bekleyen != '0);

    assign yonlendir_deger1_o = yonlendir_sec(rs1_adres_coz_i);
    assign yonlendir_deger2_o = yonlendir_sec(rs2_adres_coz_i);
    assign durdur_getir_o     = w_tehlike && !w_bosalt;
    assign durdur_coz_o       = w_durdur_coz;
    assign bosalt_getir_o     = w_bosalt;
    assign bosalt_coz_o       = w_bosalt;
    assign puan_mesgul_o      = r_mesgul;
    assign zaman_asimi_o      = r_zaman_asimi;

    // Scoreboard busy bits: completion clears, issue sets, set wins on a tie.
    // NOTE: the busy bits are control state, not data storage, so they must be
    // reset; a stale busy bit after reset would deadlock COZ.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mesgul <= '0;
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values.
            r_mesgul <= (r_mesgul & ~w_tamam_maske) | w_set_maske;
        end
    end

    // Outstanding multi-cycle operation count; issue and completion cancel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bekleyen <= '0;
        end else begin
            case ({w_verilen, w_tamam_say})
                2'b10:   r_bekleyen <= r_bekleyen + KW'(1);
                2'b01:   r_bekleyen <= r_bekleyen - KW'(1);
                default: r_bekleyen <= r_bekleyen;
            endcase
        end
    end

    // Flush window: a misprediction (re)loads the remaining cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bosalt_sayac <= '0;
        end else if (w_yanlis) begin
            r_bosalt_sayac <= BOSALT_YUKLE;
        end else if (r_bosalt_sayac != '0) begin
            r_bosalt_sayac <= r_bosalt_sayac - BW'(1);
        end
    end

    // Watchdog: consecutive COZ stall cycles; the flag is sticky until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bekci       <= '0;
            r_zaman_asimi <= 1'b0;
        end else if (w_durdur_coz) begin
            if (r_bekci != ZA_SINIR) begin
                r_bekci <= r_bekci + ZW'(1);
            end
            if (r_bekci == ZA_SINIR - ZW'(1)) begin
                r_zaman_asimi <= 1'b1;
            end
        end else begin
            r_bekci <= '0;
        end
    end

endmodule

// File: tb/tb_puanli_denetim_durum_birimi.sv
// Testbench for puanli_denetim_durum_birimi with IZ_DERINLIK=2,
// BOSALT_CEVRIM=3, ZAMAN_ASIMI=8: directed scenarios plus a randomized run
// against a cycle-level reference model.
module tb_puanli_denetim_durum_birimi;

    localparam int P_YS  = 32;
    localparam int P_AG  = 5;
    localparam int P_IZ  = 2;
    localparam int P_BOS = 3;
    localparam int P_ZA  = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            coz_gecerli_i;
    logic [P_AG-1:0] rs1_adres_coz_i, rs2_adres_coz_i, rd_adres_coz_i;
    logic            rs1_kullan_coz_i, rs2_kullan_coz_i, yaz_yazmac_coz_i, cok_cevrim_coz_i;
    logic            yaz_yazmac_yurut_i;
    logic [P_AG-1:0] rd_adres_yurut_i;
    logic            yaz_yazmac_geriyaz_i;
    logic [P_AG-1:0] rd_adres_geriyaz_i;
    logic            tamam_gecerli_i;
    logic [P_AG-1:0] tamam_rd_adres_i;
    logic            program_sayaci_gecerli_i, tahmin_dogru_i, getir_bekle_i;
    logic [1:0]      yonlendir_deger1_o, yonlendir_deger2_o;
    logic            durdur_getir_o, durdur_coz_o, bosalt_getir_o, bosalt_coz_o;
    logic [P_YS-1:0] puan_mesgul_o;
    logic            zaman_asimi_o;

    int vek  = 0;
    int hata = 0;

    // Reference model state
    bit m_busy[P_YS];
    int m_bek, m_bos, m_wd;
    bit m_flag;

    always #5 clk_i = ~clk_i;

    puanli_denetim_durum_birimi #(
        .YAZMAC_SAYISI(P_YS), .ADRES_GENISLIK(P_AG), .IZ_DERINLIK(P_IZ),
        .BOSALT_CEVRIM(P_BOS), .ZAMAN_ASIMI(P_ZA)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .coz_gecerli_i(coz_gecerli_i),
        .rs1_adres_coz_i(rs1_adres_coz_i), .rs2_adres_coz_i(rs2_adres_coz_i),
        .rd_adres_coz_i(rd_adres_coz_i),
        .rs1_kullan_coz_i(rs1_kullan_coz_i), .rs2_kullan_coz_i(rs2_kullan_coz_i),
        .yaz_yazmac_coz_i(yaz_yazmac_coz_i), .cok_cevrim_coz_i(cok_cevrim_coz_i),
        .yaz_yazmac_yurut_i(yaz_yazmac_yurut_i), .rd_adres_yurut_i(rd_adres_yurut_i),
        .yaz_yazmac_geriyaz_i(yaz_yazmac_geriyaz_i), .rd_adres_geriyaz_i(rd_adres_geriyaz_i),
        .tamam_gecerli_i(tamam_gecerli_i), .tamam_rd_adres_i(tamam_rd_adres_i),
        .program_sayaci_gecerli_i(program_sayaci_gecerli_i), .tahmin_dogru_i(tahmin_dogru_i),
        .getir_bekle_i(getir_bekle_i),
        .yonlendir_deger1_o(yonlendir_deger1_o), .yonlendir_deger2_o(yonlendir_deger2_o),
        .durdur_getir_o(durdur_getir_o), .durdur_coz_o(durdur_coz_o),
        .bosalt_getir_o(bosalt_getir_o), .bosalt_coz_o(bosalt_coz_o),
        .puan_mesgul_o(puan_mesgul_o), .zaman_asimi_o(zaman_asimi_o)
    );

    task automatic bosta();
        coz_gecerli_i = 0; rs1_adres_coz_i = '0; rs2_adres_coz_i = '0; rd_adres_coz_i = '0;
        rs1_kullan_coz_i = 0; rs2_kullan_coz_i = 0; yaz_yazmac_coz_i = 0; cok_cevrim_coz_i = 0;
        yaz_yazmac_yurut_i = 0; rd_adres_yurut_i = '0; yaz_yazmac_geriyaz_i = 0;
        rd_adres_geriyaz_i = '0; tamam_gecerli_i = 0; tamam_rd_adres_i = '0;
        program_sayaci_gecerli_i = 0; tahmin_dogru_i = 1; getir_bekle_i = 0;
    endtask

    // Leaves the bench at a falling edge with the DUT and model freshly reset.
    task automatic sifirla();
        bosta();
        rst_i = 1;
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        foreach (m_busy[r]) m_busy[r] = 0;
        m_bek = 0; m_bos = 0; m_wd = 0; m_flag = 0;
    endtask

    // Drives a multi-cycle instruction writing rd in COZ.
    task automatic cok_cevrim_ver(input int rd);
        bosta();
        coz_gecerli_i = 1; cok_cevrim_coz_i = 1; yaz_yazmac_coz_i = 1;
        rd_adres_coz_i = P_AG'(rd);
    endtask

    task automatic test_reset();
        bosta();
        rst_i = 1;
        #1;
        vek++; if (puan_mesgul_o !== '0) begin hata++; $display("FAIL rst_busy: got %h want 0", puan_mesgul_o); end
        vek++; if (zaman_asimi_o !== 1'b0) begin hata++; $display("FAIL rst_timeout: got %b want 0", zaman_asimi_o); end
        vek++; if ({durdur_getir_o, durdur_coz_o, bosalt_getir_o, bosalt_coz_o} !== 4'b0)
            begin hata++; $display("FAIL rst_ctrl: got %b want 0000", {durdur_getir_o, durdur_coz_o, bosalt_getir_o, bosalt_coz_o}); end
        vek++; if ({yonlendir_deger1_o, yonlendir_deger2_o} !== 4'b0)
            begin hata++; $display("FAIL rst_fwd: got %b want 0000", {yonlendir_deger1_o, yonlendir_deger2_o}); end
        sifirla();
    endtask

    task automatic test_forwarding();
        sifirla();
        rs1_adres_coz_i = 7; rd_adres_yurut_i = 7; rd_adres_geriyaz_i = 7;
        yaz_yazmac_yurut_i = 1; yaz_yazmac_geriyaz_i = 1;
        rs2_adres_coz_i = 3;
        #1;
        vek++; if (yonlendir_deger1_o !== 2'd1) begin hata++; $display("FAIL fwd_both: got %0d want 1", yonlendir_deger1_o); end
        vek++; if (yonlendir_deger2_o !== 2'd0) begin hata++; $display("FAIL fwd_nomatch: got %0d want 0", yonlendir_deger2_o); end
        yaz_yazmac_yurut_i = 0;
        #1;
        vek++; if (yonlendir_deger1_o !== 2'd2) begin hata++; $display("FAIL fwd_geriyaz: got %0d want 2", yonlendir_deger1_o); end
        rs1_adres_coz_i = 0; rd_adres_yurut_i = 0; rd_adres_geriyaz_i = 0; yaz_yazmac_yurut_i = 1;
        #1;
        vek++; if (yonlendir_deger1_o !== 2'd0) begin hata++; $display("FAIL fwd_x0: got %0d want 0", yonlendir_deger1_o); end
        rs2_adres_coz_i = 12; rd_adres_yurut_i = 12; rd_adres_geriyaz_i = 12;
        #1;
        vek++; if (yonlendir_deger2_o !== 2'd1) begin hata++; $display("FAIL fwd_rs2: got %0d want 1", yonlendir_deger2_o); end
        @(negedge clk_i);
    endtask

    task automatic test_scoreboard();
        sifirla();
        cok_cevrim_ver(5);
        #1;
        vek++; if (durdur_coz_o !== 1'b0) begin hata++; $display("FAIL sb_issue: got %b want 0", durdur_coz_o); end
        @(negedge clk_i);
        bosta();
        coz_gecerli_i = 1; rs1_kullan_coz_i = 1; rs1_adres_coz_i = 5;
        for (int k = 0; k < 3; k++) begin
            #1;
            vek++; if ({durdur_getir_o, durdur_coz_o} !== 2'b11)
                begin hata++; $display("FAIL sb_stall[%0d]: got %b want 11", k, {durdur_getir_o, durdur_coz_o}); end
            vek++; if (puan_mesgul_o[5] !== 1'b1) begin hata++; $display("FAIL sb_busy5[%0d]: got %b want 1", k, puan_mesgul_o[5]); end
            @(negedge clk_i);
        end
        tamam_gecerli_i = 1; tamam_rd_adres_i = 5;
        #1;
        vek++; if ({durdur_getir_o, durdur_coz_o} !== 2'b00)
            begin hata++; $display("FAIL sb_release: got %b want 00", {durdur_getir_o, durdur_coz_o}); end
        vek++; if (puan_mesgul_o[5] !== 1'b1) begin hata++; $display("FAIL sb_busy5_hold: got %b want 1", puan_mesgul_o[5]); end
        @(negedge clk_i);
        bosta();
        #1;
        vek++; if (puan_mesgul_o !== '0) begin hata++; $display("FAIL sb_cleared: got %h want 0", puan_mesgul_o); end
        @(negedge clk_i);
    endtask

    task automatic test_flush();
        sifirla();
        cok_cevrim_ver(5);
        @(negedge clk_i);
        // A RAW stall and a GETIR wait are both present during the flush.
        bosta();
        coz_gecerli_i = 1; rs1_kullan_coz_i = 1; rs1_adres_coz_i = 5; getir_bekle_i = 1;
        for (int k = 1; k <= 4; k++) begin
            program_sayaci_gecerli_i = (k == 1); tahmin_dogru_i = 0;
            #1;
            vek++; if ({bosalt_getir_o, bosalt_coz_o} !== {2{k <= 3}})
                begin hata++; $display("FAIL flush1[%0d]: got %b want %b", k, {bosalt_getir_o, bosalt_coz_o}, {2{k <= 3}}); end
            vek++; if ({durdur_getir_o, durdur_coz_o} !== {2{k > 3}})
                begin hata++; $display("FAIL flush_stall[%0d]: got %b want %b", k, {durdur_getir_o, durdur_coz_o}, {2{k > 3}}); end
            @(negedge clk_i);
        end
        sifirla();
        for (int k = 1; k <= 5; k++) begin
            program_sayaci_gecerli_i = (k <= 2); tahmin_dogru_i = 0;
            #1;
            vek++; if (bosalt_coz_o !== (k <= 4))
                begin hata++; $display("FAIL flush2[%0d]: got %b want %b", k, bosalt_coz_o, k <= 4); end
            @(negedge clk_i);
        end
        // A correct prediction never flushes.
        program_sayaci_gecerli_i = 1; tahmin_dogru_i = 1;
        #1;
        vek++; if (bosalt_coz_o !== 1'b0) begin hata++; $display("FAIL flush_correct: got %b want 0", bosalt_coz_o); end
        @(negedge clk_i);
    endtask

    task automatic test_limit();
        sifirla();
        cok_cevrim_ver(0);
        for (int k = 1; k <= 7; k++) begin
            tamam_gecerli_i = (k == 4 || k == 6); tamam_rd_adres_i = 0;
            coz_gecerli_i = (k != 6);
            #1;
            // Slots: 0,1 -> free; 2 full -> stall; completion -> issue, still 2;
            // full again; lone completion -> 1; free.
            vek++; if (durdur_coz_o !== (k == 3 || k == 5))
                begin hata++; $display("FAIL limit[%0d]: got %b want %b", k, durdur_coz_o, k == 3 || k == 5); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_watchdog();
        sifirla();
        cok_cevrim_ver(4);
        @(negedge clk_i);
        bosta();
        getir_bekle_i = 1;
        for (int k = 1; k <= P_ZA; k++) begin
            #1;
            vek++; if ({durdur_coz_o, zaman_asimi_o} !== 2'b10)
                begin hata++; $display("FAIL wd_count[%0d]: got %b want 10", k, {durdur_coz_o, zaman_asimi_o}); end
            @(negedge clk_i);
        end
        #1;
        vek++; if (zaman_asimi_o !== 1'b1) begin hata++; $display("FAIL wd_fire: got %b want 1", zaman_asimi_o); end
        getir_bekle_i = 0;
        @(negedge clk_i);
        #1;
        vek++; if ({durdur_coz_o, zaman_asimi_o} !== 2'b01)
            begin hata++; $display("FAIL wd_sticky: got %b want 01", {durdur_coz_o, zaman_asimi_o}); end
        vek++; if (puan_mesgul_o[4] !== 1'b1) begin hata++; $display("FAIL wd_busy4: got %b want 1", puan_mesgul_o[4]); end
        getir_bekle_i = 1;
        @(negedge clk_i);
        #1 rst_i = 1;
        #1;
        vek++; if ({puan_mesgul_o, zaman_asimi_o} !== '0)
            begin hata++; $display("FAIL wd_async_rst: got %h/%b want 0/0", puan_mesgul_o, zaman_asimi_o); end
        @(negedge clk_i);
        rst_i = 0;
        // The pre-reset outstanding op must be forgotten: two issues fit again.
        cok_cevrim_ver(0);
        for (int k = 1; k <= 3; k++) begin
            #1;
            vek++; if (durdur_coz_o !== (k == 3))
                begin hata++; $display("FAIL wd_cnt_clr[%0d]: got %b want %b", k, durdur_coz_o, k == 3); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_set_wins();
        sifirla();
        cok_cevrim_ver(9);
        tamam_gecerli_i = 1; tamam_rd_adres_i = 9;
        #1;
        vek++; if (durdur_coz_o !== 1'b0) begin hata++; $display("FAIL setwin_issue: got %b want 0", durdur_coz_o); end
        @(negedge clk_i);
        bosta();
        #1;
        vek++; if (puan_mesgul_o[9] !== 1'b1) begin hata++; $display("FAIL setwin_busy9: got %b want 1", puan_mesgul_o[9]); end
        @(negedge clk_i);
    endtask

    task automatic test_random();
        bit              yanlis, bos, teh, e_dg, e_dc, verilen;
        logic [1:0]      e_f1, e_f2;
        logic [P_YS-1:0] e_busy;
        int              rs1, rs2, rd, trd, ry, rg;
        sifirla();
        for (int c = 0; c < 400; c++) begin
            rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            ry = $urandom_range(0, 7); rg = $urandom_range(0, 7); trd = $urandom_range(0, 7);
            coz_gecerli_i = ($urandom_range(0, 3) != 0);
            rs1_adres_coz_i = P_AG'(rs1); rs2_adres_coz_i = P_AG'(rs2); rd_adres_coz_i = P_AG'(rd);
            rs1_kullan_coz_i = $urandom_range(0, 1); rs2_kullan_coz_i = $urandom_range(0, 1);
            yaz_yazmac_coz_i = $urandom_range(0, 1); cok_cevrim_coz_i = $urandom_range(0, 1);
            yaz_yazmac_yurut_i = $urandom_range(0, 1); rd_adres_yurut_i = P_AG'(ry);
            yaz_yazmac_geriyaz_i = $urandom_range(0, 1); rd_adres_geriyaz_i = P_AG'(rg);
            tamam_gecerli_i = (m_bek > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            tamam_rd_adres_i = P_AG'(trd);
            program_sayaci_gecerli_i = ($urandom_range(0, 15) == 0); tahmin_dogru_i = $urandom_range(0, 1);
            getir_bekle_i = ($urandom_range(0, 7) == 0);

            // Expected outputs from the rules, evaluated on the model state.
            yanlis = program_sayaci_gecerli_i && !tahmin_dogru_i;
            bos    = yanlis || (m_bos != 0);
            teh    = coz_gecerli_i && (
                       (rs1_kullan_coz_i && rs1 != 0 && m_busy[rs1] && !(tamam_gecerli_i && trd == rs1)) ||
                       (rs2_kullan_coz_i && rs2 != 0 && m_busy[rs2] && !(tamam_gecerli_i && trd == rs2)) ||
                       (yaz_yazmac_coz_i && rd != 0 && m_busy[rd] && !(tamam_gecerli_i && trd == rd)) ||
                       (cok_cevrim_coz_i && m_bek == P_IZ && !tamam_gecerli_i));
            e_dg   = teh && !bos;
            e_dc   = (teh || getir_bekle_i) && !bos;
            e_f1   = (rs1 != 0 && yaz_yazmac_yurut_i && rs1 == ry) ? 2'd1 :
                     (rs1 != 0 && yaz_yazmac_geriyaz_i && rs1 == rg) ? 2'd2 : 2'd0;
            e_f2   = (rs2 != 0 && yaz_yazmac_yurut_i && rs2 == ry) ? 2'd1 :
                     (rs2 != 0 && yaz_yazmac_geriyaz_i && rs2 == rg) ? 2'd2 : 2'd0;
            foreach (m_busy[r]) e_busy[r] = m_busy[r];
            #1;
            vek++; if (yonlendir_deger1_o !== e_f1) begin hata++; $display("FAIL rnd_fwd1 @%0d: got %0d want %0d", c, yonlendir_deger1_o, e_f1); end
            vek++; if (yonlendir_deger2_o !== e_f2) begin hata++; $display("FAIL rnd_fwd2 @%0d: got %0d want %0d", c, yonlendir_deger2_o, e_f2); end
            vek++; if (durdur_getir_o !== e_dg) begin hata++; $display("FAIL rnd_stall_getir @%0d: got %b want %b", c, durdur_getir_o, e_dg); end
            vek++; if (durdur_coz_o !== e_dc) begin hata++; $display("FAIL rnd_stall_coz @%0d: got %b want %b", c, durdur_coz_o, e_dc); end
            vek++; if ({bosalt_getir_o, bosalt_coz_o} !== {bos, bos})
                begin hata++; $display("FAIL rnd_flush @%0d: got %b want %b", c, {bosalt_getir_o, bosalt_coz_o}, {bos, bos}); end
            vek++; if (puan_mesgul_o !== e_busy) begin hata++; $display("FAIL rnd_busy @%0d: got %h want %h", c, puan_mesgul_o, e_busy); end
            vek++; if (zaman_asimi_o !== m_flag) begin hata++; $display("FAIL rnd_timeout @%0d: got %b want %b", c, zaman_asimi_o, m_flag); end

            // Advance the model to the state after this clock edge.
            verilen = coz_gecerli_i && cok_cevrim_coz_i && !e_dc && !bos;
            if (tamam_gecerli_i) m_busy[trd] = 0;
            if (verilen && yaz_yazmac_coz_i && rd != 0) m_busy[rd] = 1;
            m_bek = m_bek + (verilen ? 1 : 0) - ((tamam_gecerli_i && m_bek > 0) ? 1 : 0);
            m_bos = yanlis ? P_BOS - 1 : (m_bos > 0 ? m_bos - 1 : 0);
            if (e_dc) begin
                m_wd = m_wd + 1;
                if (m_wd >= P_ZA) m_flag = 1;
            end else begin
                m_wd = 0;
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        bosta();
        rst_i = 1;
        @(negedge clk_i);
        test_reset();
        test_forwarding();
        test_scoreboard();
        test_flush();
        test_limit();
        test_watchdog();
        test_set_wins();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vek, hata);
        $finish;
    end

endmodule

// File: doc/puanli_denetim_durum_birimi.md
Name: puanli_denetim_durum_birimi

Overview:
Parametrised successor to the core's hazard/control unit. It keeps two-source operand forwarding (YURUT, GERIYAZ) and adds three things:
- a register scoreboard that tracks in-flight multi-cycle results (bolme, carpma, bib, yapay zeka) and stalls COZ on RAW/WAW hits;
- an outstanding-operation limit;
- a parametrised multi-cycle flush window after a misprediction.

A stall watchdog flags a stuck pipeline. The block sits beside COZ and drives the stall/flush controls for GETIR and COZ.

Parameters:
YAZMAC_SAYISI, 32, number of architectural registers (busy bits)
ADRES_GENISLIK, 5, register address width; must satisfy 2^ADRES_GENISLIK >= YAZMAC_SAYISI
IZ_DERINLIK, 4, maximum outstanding multi-cycle operations
BOSALT_CEVRIM, 1, cycles bosalt_* stay high per misprediction (>=1)
ZAMAN_ASIMI, 1024, consecutive durdur_coz_o cycles before the watchdog fires

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
coz_gecerli_i  in  1  COZ holds a valid instruction
rs1_adres_coz_i  in  ADRES_GENISLIK  rs1 address in COZ
rs2_adres_coz_i  in  ADRES_GENISLIK  rs2 address in COZ
rd_adres_coz_i  in  ADRES_GENISLIK  rd address in COZ
rs1_kullan_coz_i  in  1  instruction reads rs1
rs2_kullan_coz_i  in  1  instruction reads rs2
yaz_yazmac_coz_i  in  1  instruction writes rd
cok_cevrim_coz_i  in  1  instruction goes to a multi-cycle unit
yaz_yazmac_yurut_i  in  1  YURUT writes rd
rd_adres_yurut_i  in  ADRES_GENISLIK  YURUT rd
yaz_yazmac_geriyaz_i  in  1  GERIYAZ writes rd
rd_adres_geriyaz_i  in  ADRES_GENISLIK  GERIYAZ rd
tamam_gecerli_i  in  1  a multi-cycle unit completes one operation this cycle
tamam_rd_adres_i  in  ADRES_GENISLIK  rd of the completing operation
program_sayaci_gecerli_i  in  1  branch/jump resolved in YURUT
tahmin_dogru_i  in  1  prediction was correct
getir_bekle_i  in  1  GETIR not ready
yonlendir_deger1_o  out  2  rs1 forwarding select
yonlendir_deger2_o  out  2  rs2 forwarding select
durdur_getir_o  out  1  stall GETIR
durdur_coz_o  out  1  stall COZ
bosalt_getir_o  out  1  flush GETIR
bosalt_coz_o  out  1  flush COZ
puan_mesgul_o  out  YAZMAC_SAYISI  scoreboard busy bits
zaman_asimi_o  out  1  sticky watchdog flag

Behaviour:
Reset:
- Asynchronous, active-high.
- Clears busy bits, the outstanding counter (bekleyen), the flush counter, the watchdog counter and zaman_asimi_o.
- All stall/flush outputs are therefore 0 while in reset.

Forwarding (combinational):
- Select encoding: 0 = HICBISEY, 1 = YURUT, 2 = GERIYAZ.
- rsX == rd_yurut && yaz_yurut && rsX != 0 -> YURUT.
- Otherwise, rsX == rd_geriyaz && yaz_geriyaz && rsX != 0 -> GERIYAZ.
- Otherwise HICBISEY. YURUT has priority.

Misprediction and flush:
- yanlis = program_sayaci_gecerli_i && !tahmin_dogru_i.
- bosalt_getir_o = bosalt_coz_o = yanlis || (bosalt_sayac != 0).
- When yanlis is high, bosalt_sayac loads BOSALT_CEVRIM-1; otherwise it decrements toward 0.
- A new yanlis inside the window restarts it.
- BOSALT_CEVRIM = 1 gives a single-cycle, purely combinational flush.

Hazard detection:
- Effective busy: mesgul_e = busy & ~(tamam_gecerli_i ? onehot(tamam_rd_adres_i) : 0). A same-cycle completion releases its hazard.
- tehlike is high when coz_gecerli_i and any of the following holds:
  - rs1 is used, rs1 != 0 and mesgul_e[rs1];
  - rs2 is used, rs2 != 0 and mesgul_e[rs2];
  - yaz_yazmac_coz_i, rd != 0 and mesgul_e[rd] (WAW);
  - cok_cevrim_coz_i and the counter full condition: bekleyen == IZ_DERINLIK && !tamam_gecerli_i.

Stall outputs:
- durdur_getir_o = tehlike && !bosalt_coz_o.
- durdur_coz_o = (tehlike || getir_bekle_i) && !bosalt_coz_o. Flush overrides stall.

Issue:
- verilen = coz_gecerli_i && cok_cevrim_coz_i && !durdur_coz_o && !bosalt_coz_o.
- On verilen, the busy bit for rd is set next cycle if yaz_yazmac_coz_i && rd != 0.
- Set beats clear on the same register.

Completion:
- tamam_gecerli_i clears busy[tamam_rd_adres_i] next cycle. Address 0 has no busy effect.

Counter (bekleyen):
- +1 on verilen, -1 on tamam_gecerli_i, net 0 when both occur in the same cycle.
- A completion while the counter is 0 is ignored (no underflow).
- The counter never exceeds IZ_DERINLIK.

Watchdog:
- Counts consecutive cycles with durdur_coz_o high and resets to 0 on any cycle where it is low.
- On reaching ZAMAN_ASIMI it sets zaman_asimi_o, which stays high until reset and does not affect stalls.

Test Plan:
- Multi-cycle op (rd=x5) issues; next instruction reads rs1=x5 -> durdur_getir_o = durdur_coz_o = 1 and puan_mesgul_o[5] = 1 until tamam_gecerli_i with rd=5; in that same cycle the stall drops to 0 and bit 5 clears next cycle.
- rs1 = rd_yurut = rd_geriyaz = 7, both writes high -> yonlendir_deger1_o = 1; only geriyaz -> 2; rs1 = 0 with rd = 0 -> 0.
- BOSALT_CEVRIM=3: one yanlis pulse -> bosalt_* high exactly 3 cycles; a second pulse in cycle 2 extends the window to cycle 4; a stall present during the flush -> durdur_* = 0.
- IZ_DERINLIK=2: issue 2 ops to rd=0 with no completion -> a third multi-cycle op stalls; tamam_gecerli_i in the same cycle -> it issues and bekleyen stays 2.
- ZAMAN_ASIMI=8: hold getir_bekle_i for 8 cycles -> zaman_asimi_o rises at the 8th and stays high after the stall ends; rst_i mid-stall -> all busy bits and counters 0 asynchronously.
- Issue to rd=9 and complete rd=9 in the same cycle -> busy[9] = 1 afterwards (set wins).
